// File: rtl/nn_pkg.sv
// Shared types for the 2x2 network feeder: data word, buffered row and feeder FSM states.
package nn_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef struct packed {
    data_t c1;
    data_t c2;
  } row_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_START,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } feeder_state_e;

endpackage

// File: rtl/nn_row_fifo.sv
// Circular row buffer with a peek port addressed relative to the head, so rows can be
// read in order either by popping (consume) or by walking peek_idx (read without pop).
module nn_row_fifo
  import nn_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  row_t          push_row,
  input  logic          pop,
  input  logic [AW-1:0] peek_idx,
  output row_t          peek_row,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  row_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] peek_addr;
  logic          push_ok;
  logic          pop_ok;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign peek_addr = rd_ptr + peek_idx;
  assign peek_row  = mem[peek_addr];

  // Storage carries no reset; count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_row;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/nn_feeder.sv
// Host-side feeder for the 2x2 network: buffers rows, holds weights, and on go streams
// load-weights, start, then rows with column 2 skewed one cycle. Option: NN_FEEDER_REPLAY_EN.
module nn_feeder
  import nn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic signed [DATA_W-1:0] wr_data_1,
  input  logic signed [DATA_W-1:0] wr_data_2,
  input  logic                     cfg_valid,
  input  logic signed [DATA_W-1:0] cfg_weight_11,
  input  logic signed [DATA_W-1:0] cfg_weight_12,
  input  logic signed [DATA_W-1:0] cfg_weight_21,
  input  logic signed [DATA_W-1:0] cfg_weight_22,
  input  logic                     go,
`ifdef NN_FEEDER_REPLAY_EN
  input  logic                     clear,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     nn_valid_load_weights,
  output logic                     nn_start,
  output logic signed [DATA_W-1:0] nn_temp_weight_11,
  output logic signed [DATA_W-1:0] nn_temp_weight_12,
  output logic signed [DATA_W-1:0] nn_temp_weight_21,
  output logic signed [DATA_W-1:0] nn_temp_weight_22,
  output logic signed [DATA_W-1:0] nn_data_in_1,
  output logic signed [DATA_W-1:0] nn_data_in_2,
  output logic                     nn_valid_in_1,
  output logic                     nn_valid_in_2,
  output feeder_state_e            dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  feeder_state_e state;
  logic [CW-1:0] count;
  logic [CW-1:0] n_rows;
  logic [CW-1:0] k;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          clr;
  logic          read_now;
  logic          start_pass;
  logic [AW-1:0] peek_idx;
  row_t          push_row;
  row_t          peek_row;
  data_t         skew_c2;

  // Host write handshake: a row transfers on a clock edge where wr_valid && wr_ready;
  // wr_ready never depends on wr_valid, and a refused row must be held by the host.
  assign wr_ready    = (state == ST_IDLE) && !full;
  assign push        = wr_valid && wr_ready;
  assign push_row.c1 = wr_data_1;
  assign push_row.c2 = wr_data_2;
  assign start_pass  = (state == ST_IDLE) && go && !clr && (!empty || push);
  assign read_now    = (state == ST_LOAD_W) ||
                       (((state == ST_START) || (state == ST_STREAM)) && (k < n_rows));

`ifdef NN_FEEDER_REPLAY_EN
  // Rows stay resident; the pass walks them by offset so a later go replays them.
  assign clr      = (state == ST_IDLE) && clear;
  assign pop      = 1'b0;
  assign peek_idx = k[AW-1:0];
`else
  assign clr      = 1'b0;
  assign pop      = read_now;
  assign peek_idx = '0;
`endif

  assign dbg_state = state;
  assign dbg_count = count;

  nn_row_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (clr),
    .push     (push),
    .push_row (push_row),
    .pop      (pop),
    .peek_idx (peek_idx),
    .peek_row (peek_row),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= ST_IDLE;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      nn_valid_load_weights <= 1'b0;
      nn_start              <= 1'b0;
      nn_temp_weight_11     <= '0;
      nn_temp_weight_12     <= '0;
      nn_temp_weight_21     <= '0;
      nn_temp_weight_22     <= '0;
      nn_data_in_1          <= '0;
      nn_data_in_2          <= '0;
      nn_valid_in_1         <= 1'b0;
      nn_valid_in_2         <= 1'b0;
      n_rows                <= '0;
      k                     <= '0;
      skew_c2               <= '0;
    end else begin
      nn_valid_load_weights <= 1'b0;
      nn_start              <= 1'b0;
      done                  <= 1'b0;
      if ((state == ST_IDLE) && cfg_valid) begin
        nn_temp_weight_11 <= cfg_weight_11;
        nn_temp_weight_12 <= cfg_weight_12;
        nn_temp_weight_21 <= cfg_weight_21;
        nn_temp_weight_22 <= cfg_weight_22;
      end
      case (state)
        ST_IDLE: begin
          if (start_pass) begin
            state                 <= ST_LOAD_W;
            nn_valid_load_weights <= 1'b1;
            busy                  <= 1'b1;
            n_rows                <= count + CW'(push);
            k                     <= '0;
          end
        end
        ST_LOAD_W: begin
          state         <= ST_START;
          nn_start      <= 1'b1;
          nn_data_in_1  <= peek_row.c1;
          nn_valid_in_1 <= 1'b1;
          skew_c2       <= peek_row.c2;
          k             <= k + CW'(1);
        end
        ST_START, ST_STREAM: begin
          nn_data_in_2  <= skew_c2;
          nn_valid_in_2 <= 1'b1;
          if (read_now) begin
            state        <= ST_STREAM;
            nn_data_in_1 <= peek_row.c1;
            skew_c2      <= peek_row.c2;
            k            <= k + CW'(1);
          end else begin
            state         <= ST_DRAIN;
            nn_data_in_1  <= '0;
            nn_valid_in_1 <= 1'b0;
            skew_c2       <= '0;
          end
        end
        ST_DRAIN: begin
          state         <= ST_DONE;
          nn_data_in_2  <= '0;
          nn_valid_in_2 <= 1'b0;
          done          <= 1'b1;
          busy          <= 1'b0;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
